// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Purpose : Shared constants, types and helpers for the instruction memory.
//   IMEM_WIDTH  default data/address bus width
//   IMEM_DEPTH  default number of words
//   word_t      one memory word at the default width
//   idx_width() index width for a given depth, never smaller than 1 bit
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int unsigned IMEM_WIDTH = 32'd32;
    localparam int unsigned IMEM_DEPTH = 32'd64;

    typedef logic [IMEM_WIDTH-1:0] word_t;

    // A depth of 1 still needs a 1-bit index so that the slices stay legal.
    function automatic int unsigned idx_width(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) begin
            w = $clog2(depth);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage : imem_pkg

// File: rtl/imem_array.sv
// ----------------------------------------------------------------------------
// imem_array
// Purpose : Word storage for imem with synchronous clear and write.
//           The read port is a raw, unchecked combinational lookup; any
//           range qualification is the caller's job.
// Ports   :
//   clk      in   clock, state changes on posedge
//   rst      in   synchronous active-high reset, clears every word
//   wr_en    in   write strobe, already range-qualified by the caller
//   wr_idx   in   word index to write
//   wr_data  in   write data
//   rd_idx   in   word index to read
//   rd_data  out  mem[rd_idx], combinational
// ----------------------------------------------------------------------------
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned WIDTH  = IMEM_WIDTH,
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage update: reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Raw combinational read; no bypass of a write in flight.
    assign rd_data = mem_r[rd_idx];

endmodule : imem_array

// File: rtl/imem.sv
// ----------------------------------------------------------------------------
// imem
// Purpose : Single-port instruction memory. One synchronous write port and
//           one combinational read port sharing the address bus i_addr.
//           Addresses at or beyond DEPTH never write and read as zero; there
//           is no wrap-around onto low words.
// Ports   :
//   clk       in   clock, state changes on posedge
//   rst       in   synchronous active-high reset, clears every word
//   i_addr    in   word address shared by read and write
//   wre       in   write enable, sampled at posedge clk
//   wr_data   in   write data
//   i_data    out  mem[i_addr] (0 when out of range), combinational
//   addr_err  out  i_addr >= DEPTH; only when IMEM_ADDR_CHECK_EN is defined
// Configuration macro: IMEM_ADDR_CHECK_EN
// ----------------------------------------------------------------------------
module imem
    import imem_pkg::*;
#(
    parameter int unsigned WIDTH  = IMEM_WIDTH,
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    localparam int unsigned ADDR_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_addr,
    input  logic             wre,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] i_data
`ifdef IMEM_ADDR_CHECK_EN
    ,
    output logic             addr_err
`endif
);

    logic              in_range_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] idx_s;
    logic [WIDTH-1:0]  rd_data_s;

    // Full-width compare so that high address bits can never alias low words.
    assign in_range_s = (i_addr < WIDTH'(DEPTH));
    assign idx_s      = i_addr[ADDR_W-1:0];
    assign wr_en_s    = wre & in_range_s;

    imem_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_s),
        .wr_data (wr_data),
        .rd_idx  (idx_s),
        .rd_data (rd_data_s)
    );

    // Read mux: out-of-range addresses return zero.
    always_comb begin
        i_data = {WIDTH{1'b0}};
        if (in_range_s) begin
            i_data = rd_data_s;
        end else begin
            i_data = {WIDTH{1'b0}};
        end
    end

`ifdef IMEM_ADDR_CHECK_EN
    assign addr_err = ~in_range_s;

    // Simulation-only notice for writes that are dropped for being out of range.
    always @(posedge clk) begin
        if (!rst && wre && !in_range_s) begin
            $display("imem: warning: write to out-of-range address 0x%h ignored", i_addr);
        end
    end
`endif

endmodule : imem

// File: tb/tb_imem.sv
// ----------------------------------------------------------------------------
// tb_imem
// Directed self-checking bench for imem. Inputs change on the falling edge,
// outputs are sampled 1ns after input changes or after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr;
    logic        wre;
    logic [31:0] wr_data;
    logic [31:0] i_data;
`ifdef IMEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int check_cnt;
    int pass_cnt;

    imem dut (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (i_addr),
        .wre     (wre),
        .wr_data (wr_data),
        .i_data  (i_data)
`ifdef IMEM_ADDR_CHECK_EN
        ,
        .addr_err(addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        i_addr  = a;
        wr_data = d;
        wre     = 1'b1;
        @(negedge clk);
        wre     = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'd0; addrs[1] = 32'd17; addrs[2] = 32'd63;
        rst = 1'b1; wre = 1'b0; i_addr = 32'd0; wr_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_addr = addrs[k];
            #1;
            check_cnt++;
            if (i_data !== 32'd0)
                $display("FAIL reset_clear addr=%0d got=0x%h exp=0x00000000", addrs[k], i_data);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 49; i++) begin
            @(negedge clk);
            i_addr  = i - 1;
            wr_data = i;
            wre     = 1'b1;
        end
        @(negedge clk);
        wre = 1'b0;
        for (int a = 0; a < 49; a++) begin
            i_addr = a;
            #1;
            check_cnt++;
            if (i_data !== a + 1)
                $display("FAIL fill addr=%0d got=0x%h exp=0x%h", a, i_data, a + 1);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        wre = 1'b0;
        wr_data = 32'hFFFF_FFFF;
        repeat (20) @(negedge clk);
        for (int a = 0; a < 49; a++) begin
            i_addr = a;
            #1;
            check_cnt++;
            if (i_data !== a + 1)
                $display("FAIL hold addr=%0d got=0x%h exp=0x%h", a, i_data, a + 1);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_rdw();
        write_word(32'd5, 32'd5);
        i_addr  = 32'd5;
        wr_data = 32'hA5A5_A5A5;
        wre     = 1'b1;
        #1;
        check_cnt++;
        if (i_data !== 32'd5)
            $display("FAIL rdw_before got=0x%h exp=0x00000005", i_data);
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        check_cnt++;
        if (i_data !== 32'hA5A5_A5A5)
            $display("FAIL rdw_after got=0x%h exp=0xa5a5a5a5", i_data);
        else
            pass_cnt++;
        @(negedge clk);
        wre = 1'b0;
        // Neighbour must not be disturbed by the write.
        i_addr = 32'd6;
        #1;
        check_cnt++;
        if (i_data !== 32'd7)
            $display("FAIL rdw_neighbour got=0x%h exp=0x00000007", i_data);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; wre = 1'b1; i_addr = 32'd3; wr_data = 32'h33;
        @(negedge clk);
        rst = 1'b0; wre = 1'b0;
        #1;
        check_cnt++;
        if (i_data !== 32'd0)
            $display("FAIL reset_priority addr=3 got=0x%h exp=0x00000000", i_data);
        else
            pass_cnt++;
        i_addr = 32'd10;
        #1;
        check_cnt++;
        if (i_data !== 32'd0)
            $display("FAIL reset_priority_clear addr=10 got=0x%h exp=0x00000000", i_data);
        else
            pass_cnt++;
    endtask

    task automatic test_out_of_range();
        write_word(32'd0, 32'h1234_5678);
        write_word(32'd64, 32'hDEAD);
        i_addr = 32'd64;
        #1;
        check_cnt++;
        if (i_data !== 32'd0)
            $display("FAIL oor_read addr=64 got=0x%h exp=0x00000000", i_data);
        else
            pass_cnt++;
`ifdef IMEM_ADDR_CHECK_EN
        check_cnt++;
        if (addr_err !== 1'b1)
            $display("FAIL addr_err_64 got=%b exp=1", addr_err);
        else
            pass_cnt++;
`endif
        i_addr = 32'd0;
        #1;
        check_cnt++;
        if (i_data !== 32'h1234_5678)
            $display("FAIL oor_no_alias addr=0 got=0x%h exp=0x12345678", i_data);
        else
            pass_cnt++;
        // A high address whose low bits select word 1 must also be rejected.
        write_word(32'd1, 32'h0000_0011);
        write_word(32'h8000_0001, 32'hBEEF);
        i_addr = 32'd1;
        #1;
        check_cnt++;
        if (i_data !== 32'h0000_0011)
            $display("FAIL oor_high_alias addr=1 got=0x%h exp=0x00000011", i_data);
        else
            pass_cnt++;
        i_addr = 32'd63;
        #1;
        check_cnt++;
        if (i_data !== 32'd0)
            $display("FAIL edge_63 got=0x%h exp=0x00000000", i_data);
        else
            pass_cnt++;
`ifdef IMEM_ADDR_CHECK_EN
        check_cnt++;
        if (addr_err !== 1'b0)
            $display("FAIL addr_err_63 got=%b exp=0", addr_err);
        else
            pass_cnt++;
`endif
        write_word(32'd63, 32'hCAFE_0063);
        i_addr = 32'd63;
        #1;
        check_cnt++;
        if (i_data !== 32'hCAFE_0063)
            $display("FAIL write_63 got=0x%h exp=0xcafe0063", i_data);
        else
            pass_cnt++;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b1; wre = 1'b0; i_addr = 32'd0; wr_data = 32'd0;
        test_reset();
        test_fill();
        test_hold();
        test_rdw();
        test_reset_priority();
        test_out_of_range();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_imem
